mem_access_ctrl: RTL and testbench

//   MEM-stage initiator for the word-wide data memory: turns pipeline load/store requests
//   (byte/half/word, signed/unsigned) into word accesses.
//   Sub-word stores use read-modify-write; loads are lane-extracted and extended.

---
 rtl/mem_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller for a word-wide synchronous-read memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero extended.
module mem_access_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_pc,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RSP} state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t            state;
  logic [2:0]        cnt;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       mem_pc_q;

  logic              req_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  always_comb begin
    req_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  // Lane select and merge operate on the live read data during the last WAIT cycle.
  always_comb begin
    case (lane_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      2'b00:   load_data = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_pc_q    <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            if (req_err) begin
              state       <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_pc_q   <= req_pc;
              if (req_we && req_size == 2'b10) begin
                state       <= WR;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
                rsp_valid_q <= 1'b1;
              end else begin
                state    <= RD;
                mem_re_q <= 1'b1;
              end
            end
          end
        end
        RD: begin
          state <= WAIT;
          cnt   <= LAT;
          if (!we_q && LAT == 3'd1) rsp_valid_q <= 1'b1;
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            cnt <= '0;
            if (we_q) begin
              state       <= WR;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= merged;
              rsp_valid_q <= 1'b1;
            end else begin
              state      <= IDLE;
              mem_addr_q <= '0;
              mem_pc_q   <= '0;
            end
          end else begin
            cnt <= cnt - 3'd1;
            // Raise the load response so it lines up with the final WAIT cycle.
            if (!we_q && cnt == 3'd2) rsp_valid_q <= 1'b1;
          end
        end
        WR: begin
          state       <= IDLE;
          mem_addr_q  <= '0;
          mem_pc_q    <= '0;
          mem_wdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_err   = rsp_err_q && !reset;
  assign rsp_rdata = (rsp_valid && state == WAIT) ? load_data : 32'h0;
  assign mem_we    = mem_we_q && !reset;
  assign mem_re    = mem_re_q && !reset;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_pc    = mem_pc_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl at read latencies 1 and 3.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;

  logic [1:0]  req_ready, rsp_valid, rsp_err, mem_we, mem_re;
  logic [31:0] rsp_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_pc    [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] tmem0 [64];
  logic [31:0] tmem1 [64];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];
  logic [31:0] model [64];
  logic [31:0] last_rd [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_re(mem_re[0]), .mem_pc(mem_pc[0]), .mem_rdata(mem_rdata[0])
  );

  mem_access_ctrl #(.ADDR_W(32), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_re(mem_re[1]), .mem_pc(mem_pc[1]), .mem_rdata(mem_rdata[1])
  );

  // Word-addressed memories; read data is junk unless a read strobe launched it.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 64; j++) tmem0[j] <= 32'h0;
    end else if (mem_we[0]) begin
      tmem0[mem_addr[0][7:2]] <= mem_wdata[0];
    end
    pipe0 <= mem_re[0] ? tmem0[mem_addr[0][7:2]] : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 64; j++) tmem1[j] <= 32'h0;
    end else if (mem_we[1]) begin
      tmem1[mem_addr[1][7:2]] <= mem_wdata[1];
    end
    pipe1[0] <= mem_re[1] ? tmem1[mem_addr[1][7:2]] : 32'hBAD1_BAD1;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  assign mem_rdata[0] = pipe0;
  assign mem_rdata[1] = pipe1[2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ready"}, req_ready[i], 1);
      chk({tag, "_outs"}, {rsp_valid[i], rsp_err[i], mem_we[i], mem_re[i]}, 0);
      chk({tag, "_rdata"}, rsp_rdata[i], 0);
      chk({tag, "_addr"}, mem_addr[i], 0);
      chk({tag, "_wdata"}, mem_wdata[i], 0);
      chk({tag, "_pc"}, mem_pc[i], 0);
    end
  endtask

  // Drives one request (caller is just after a falling edge) and checks both instances.
  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [7:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
    logic [31:0] w, exp_rd, new_w, v;
    logic        err;
    int          sh, lat [2], nrsp [2], nwe [2], nre [2], rcyc [2], maxlat;
    w   = model[addr[7:2]];
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    exp_rd = 32'h0;
    new_w  = w;
    if (size == 2'b00) begin
      sh = 8 * int'(addr[1:0]);
      v  = (w >> sh) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      exp_rd = v;
      new_w  = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
    end else if (size == 2'b01) begin
      sh = 16 * int'(addr[1]);
      v  = (w >> sh) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
      new_w  = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
    end else begin
      exp_rd = w;
      new_w  = wdata;
    end
    if (we || err) exp_rd = 32'h0;
    for (int i = 0; i < 2; i++) begin
      if (err || (we && size == 2'b10)) lat[i] = 1;
      else if (!we)                     lat[i] = 1 + lat_of(i);
      else                              lat[i] = 2 + lat_of(i);
      nrsp[i] = 0; nwe[i] = 0; nre[i] = 0; rcyc[i] = 0;
    end
    maxlat = lat[1];

    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = {24'h0, addr}; req_wdata = wdata; req_pc = pc;
    for (int k = 1; k <= maxlat; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (k <= lat[i]) chk("busy_ready", req_ready[i], 0);
        if (rsp_valid[i]) begin
          nrsp[i]++;
          rcyc[i] = k;
          last_rd[i] = rsp_rdata[i];
          chk("rsp_rdata", rsp_rdata[i], exp_rd);
          chk("rsp_err", rsp_err[i], err);
        end
        if (mem_re[i]) begin
          nre[i]++;
          chk("re_cycle", k, 1);
          chk("re_addr", mem_addr[i], {24'h0, addr[7:2], 2'b00});
          chk("re_pc", mem_pc[i], pc);
        end
        if (mem_we[i]) begin
          nwe[i]++;
          chk("we_cycle", k, lat[i]);
          chk("we_addr", mem_addr[i], {24'h0, addr[7:2], 2'b00});
          chk("we_data", mem_wdata[i], new_w);
          chk("we_pc", mem_pc[i], pc);
        end else begin
          chk("wdata_quiet", mem_wdata[i], 0);
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rsp_count", nrsp[i], 1);
      chk("rsp_latency", rcyc[i], lat[i]);
      chk("we_count", nwe[i], (we && !err) ? 1 : 0);
      chk("re_count", nre[i], (!err && !(we && size == 2'b10)) ? 1 : 0);
      chk("ready_after", req_ready[i], 1);
      chk("addr_after", mem_addr[i], 0);
      chk("pc_after", mem_pc[i], 0);
    end
    if (we && !err) model[addr[7:2]] = new_w;
  endtask

  initial begin
    for (int j = 0; j < 64; j++) model[j] = 32'h0;
    @(negedge clk);
    chk("reset_ready0", req_ready[0], 0);
    chk("reset_ready1", req_ready[1], 0);
    chk("reset_we_re", {mem_we, mem_re}, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_init = 1'b0;
    #1;
    chk_idle("post_reset");

    // word store, read-modify-write sub-word stores
    xact(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, 32'h0000_1000);
    xact(1'b1, 2'b10, 1'b0, 8'h10, 32'h1122_3344, 32'h0000_1004);
    xact(1'b1, 2'b00, 1'b0, 8'h12, 32'h0000_00AA, 32'h0000_1008);
    xact(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0000_100C);
    chk("sb_merge0", last_rd[0], 32'h11AA_3344);
    chk("sb_merge1", last_rd[1], 32'h11AA_3344);
    xact(1'b1, 2'b10, 1'b0, 8'h10, 32'h1122_3344, 32'h0000_1010);
    xact(1'b1, 2'b01, 1'b0, 8'h12, 32'h0000_BEEF, 32'h0000_1014);

    // load extension
    xact(1'b1, 2'b10, 1'b0, 8'h20, 32'h8001_F080, 32'h0000_2000);
    xact(1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 32'h0000_2004);
    chk("lb_signed", last_rd[0], 32'hFFFF_FF80);
    xact(1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 32'h0000_2008);
    chk("lbu", last_rd[1], 32'h0000_0080);
    xact(1'b0, 2'b01, 1'b1, 8'h22, 32'h0, 32'h0000_200C);
    chk("lh_signed", last_rd[0], 32'hFFFF_8001);
    xact(1'b0, 2'b01, 1'b0, 8'h22, 32'h0, 32'h0000_2010);
    chk("lhu", last_rd[1], 32'h0000_8001);
    xact(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 32'h0000_2014);
    chk("lw", last_rd[0], 32'h8001_F080);

    // error requests
    xact(1'b0, 2'b10, 1'b0, 8'h21, 32'h0, 32'h0000_3000);
    xact(1'b1, 2'b01, 1'b0, 8'h13, 32'h0000_5555, 32'h0000_3004);
    xact(1'b0, 2'b11, 1'b1, 8'h20, 32'h0, 32'h0000_3008);

    // reset in the WAIT phase of a byte store abandons it
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h0000_0055; req_pc = 32'h0000_4000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mid_ready", req_ready[i], 0);
      chk("rst_mid_we", mem_we[i], 0);
      chk("rst_mid_rsp", rsp_valid[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_idle("after_abort");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_we", mem_we, 0);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    xact(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0000_4004);
    chk("abort_mem0", last_rd[0], 32'hBEEF_3344);
    chk("abort_mem1", last_rd[1], 32'hBEEF_3344);

    // back-to-back load then store
    xact(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 32'h0000_5000);
    xact(1'b1, 2'b10, 1'b0, 8'h24, 32'hCAFE_F00D, 32'h0000_5004);

    for (int n = 0; n < 80; n++) begin
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
